// File: rtl/dp_arbiter.sv
// dp_arbiter: four-client round-robin arbiter that serializes
// latched client requests onto the single datapath port.
module dp_arbiter #(
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [3:0]              start_c,
    input  logic [4*INSTR_W-1:0]    instruction_c,
    output logic [3:0]              finished_c,
    output logic [4*RESULT_W-1:0]   result_c,
    output logic                    start_dp,
    output logic [INSTR_W-1:0]      instruction_dp,
    input  logic                    finished_dp,
    input  logic [RESULT_W-1:0]     result_dp,
    output logic [1:0]              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                busy_q, busy_d;
    logic [3:0][INSTR_W-1:0]   instr_q, instr_d;
    logic [3:0][RESULT_W-1:0]  result_q, result_d;
    logic [1:0]                rr_q, rr_d;
    logic [1:0]                owner_q, owner_d;
    logic                      start_q, start_d;
    logic [INSTR_W-1:0]        idp_q, idp_d;
    logic                      gnt_found;
    logic [1:0]                gnt_idx;

    // Find the first latched request at or above the rr pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        for (int k = 0; k < 4; k++) begin
            if (!gnt_found && busy_q[rr_q + 2'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_q + 2'(k);
            end
        end
    end

    // Request capture, grant sequencing and result return.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        instr_d  = instr_q;
        result_d = result_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        start_d  = start_q;
        idp_d    = idp_q;

        for (int i = 0; i < 4; i++) begin
            if (start_c[i] && !busy_q[i]) begin
                busy_d[i]  = 1'b1;
                instr_d[i] = instruction_c[i*INSTR_W +: INSTR_W];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    idp_d   = instr_q[gnt_idx];
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                start_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (finished_dp) begin
                    result_d[owner_q] = result_dp;
                    busy_d[owner_q]   = 1'b0;
                    rr_d              = owner_q + 2'd1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath-facing registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            instr_q  <= '0;
            result_q <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
            start_q  <= 1'b0;
            idp_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            start_q  <= start_d;
            idp_q    <= idp_d;
        end
    end

    assign finished_c     = ~busy_q;
    assign result_c       = result_q;
    assign start_dp       = start_q;
    assign instruction_dp = idp_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: directed and random requests against a
// transaction-timeline model of the arbiter.
module tb_dp_arbiter;

    logic         clock;
    logic         resetn;
    logic [3:0]   start_c;
    logic [127:0] instruction_c;
    logic [3:0]   finished_c;
    logic [127:0] result_c;
    logic         start_dp;
    logic [31:0]  instruction_dp;
    logic         finished_dp;
    logic [31:0]  result_dp;
    logic [1:0]   owner;

    dp_arbiter #(.INSTR_W(32), .RESULT_W(32)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start_c        (start_c),
        .instruction_c  (instruction_c),
        .finished_c     (finished_c),
        .result_c       (result_c),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .owner          (owner)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int nchk;
    int nerr;
    int edge_n;

    // Reference model: pending set, capture edge, round-robin
    // pointer and the grant edge of the transaction in flight.
    bit [3:0]    m_pend;
    logic [31:0] m_instr [4];
    logic [31:0] m_res [4];
    int          m_cap [4];
    int          m_rr;
    int          m_cur;
    int          m_gedge;
    logic [31:0] m_dp;
    logic [1:0]  m_own;
    int          m_done [4];

    // Datapath responder.
    bit          dp_act;
    int          dp_cnt;
    int          dp_lat;
    int          dp_hi;
    logic [31:0] dp_instr;
    int          next_lat;
    logic [1:0]  served_q [$];

    function automatic logic [31:0] f(input logic [31:0] x);
        return (x & 32'h0FFF_FFFF) << 1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_rr    = 0;
        m_cur   = -1;
        m_gedge = 0;
        m_dp    = '0;
        m_own   = '0;
        for (int i = 0; i < 4; i++) begin
            m_res[i]   = '0;
            m_instr[i] = '0;
            m_cap[i]   = -1;
        end
    endtask

    task automatic model_edge(input logic [3:0] s_start,
                              input logic [127:0] s_ins,
                              input logic s_fin);
        bit [3:0] pre;
        bit       found;
        int       j;
        pre = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (s_start[i] && !pre[i]) begin
                m_pend[i]  = 1'b1;
                m_instr[i] = s_ins[i*32 +: 32];
                m_cap[i]   = edge_n;
            end
        end
        if (m_cur < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                j = (m_rr + k) % 4;
                if (!found && pre[j] && m_cap[j] != edge_n) begin
                    found   = 1'b1;
                    m_cur   = j;
                    m_gedge = edge_n;
                    m_dp    = m_instr[j];
                    m_own   = 2'(j);
                end
            end
        end else if (edge_n >= m_gedge + 3 && s_fin) begin
            m_res[m_cur]  = f(m_instr[m_cur]);
            m_pend[m_cur] = 1'b0;
            m_done[m_cur]++;
            m_rr          = (m_cur + 1) % 4;
            m_cur         = -1;
        end
    endtask

    task automatic check_outputs();
        logic [3:0]   ef;
        logic [127:0] er;
        for (int i = 0; i < 4; i++) begin
            ef[i]          = ~m_pend[i];
            er[i*32 +: 32] = m_res[i];
        end
        chk("start_dp", start_dp,
            (m_cur >= 0 && edge_n - m_gedge < 2));
        chk("instr_dp", instruction_dp, m_dp);
        chk("owner", owner, m_own);
        chk("finished_c", finished_c, ef);
        chk("result_c", result_c, er);
    endtask

    task automatic responder();
        finished_dp = 1'b0;
        result_dp   = $urandom;
        if (!resetn) begin
            dp_act = 1'b0;
            return;
        end
        if (!dp_act) begin
            if (start_dp) begin
                dp_act   = 1'b1;
                dp_cnt   = 0;
                dp_hi    = 1;
                dp_instr = instruction_dp;
                dp_lat   = (next_lat > 0) ? next_lat
                                          : int'($urandom_range(1, 8));
                served_q.push_back(owner);
            end
        end else begin
            dp_cnt++;
            if (start_dp) dp_hi++;
            if (dp_cnt >= 2) chk("one_inflight", start_dp, 1'b0);
            if (dp_cnt == 1 + dp_lat) begin
                finished_dp = 1'b1;
                result_dp   = f(dp_instr);
                dp_act      = 1'b0;
                chk("start_len", dp_hi, 2);
            end
        end
    endtask

    task automatic tick();
        logic [3:0]   s_start;
        logic [127:0] s_ins;
        logic         s_fin;
        s_start = start_c;
        s_ins   = instruction_c;
        s_fin   = finished_dp;
        @(posedge clock);
        edge_n++;
        if (resetn) model_edge(s_start, s_ins, s_fin);
        #1;
        check_outputs();
        responder();
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        start_c     = '0;
        finished_dp = 1'b0;
        dp_act      = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_finished", finished_c, 4'hF);
        chk("rst_start", start_dp, 1'b0);
    endtask

    task automatic set_ins(input int c, input logic [31:0] v);
        instruction_c[c*32 +: 32] = v;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_pend != 0 || dp_act) && t < 300) begin
            tick();
            t++;
        end
        chk("idle_timeout", t < 300, 1'b1);
        tick();
    endtask

    logic [31:0] ins;

    initial begin
        nchk          = 0;
        nerr          = 0;
        edge_n        = 0;
        next_lat      = 2;
        start_c       = '0;
        instruction_c = '0;
        finished_dp   = 1'b0;
        result_dp     = '0;
        resetn        = 1'b1;
        dp_act        = 1'b0;
        for (int i = 0; i < 4; i++) m_done[i] = 0;
        #1;
        do_reset();
        #1;
        resetn = 1'b1;

        // Single request from client 0.
        set_ins(0, 32'h2000_0005);
        start_c[0] = 1'b1;
        tick();
        tick();
        start_c = '0;
        wait_idle();
        chk("t1_result0", result_c[31:0], 32'h0000_000A);
        chk("t1_instr_dp", instruction_dp, 32'h2000_0005);
        chk("t1_finished", finished_c, 4'hF);

        // Simultaneous requests from 0, 1 and 3 after a fresh reset.
        do_reset();
        tick();
        resetn = 1'b1;
        served_q.delete();
        next_lat = 0;
        set_ins(0, 32'h0100_0011);
        set_ins(1, 32'h0200_0022);
        set_ins(3, 32'h0300_0033);
        start_c = 4'b1011;
        tick();
        chk("t2_fin_low", finished_c, 4'b0100);
        tick();
        start_c = '0;
        wait_idle();
        chk("t2_order", {served_q.size() == 3, served_q[0],
                         served_q[1], served_q[2]},
            {1'b1, 2'd0, 2'd1, 2'd3});
        chk("t2_res2", result_c[95:64], 32'h0);
        chk("t2_res3", result_c[127:96], 32'h0600_0066);

        // Fairness: 0 and 2 arrive while 1 is served.
        served_q.delete();
        next_lat = 4;
        set_ins(1, 32'h0000_0101);
        start_c[1] = 1'b1;
        tick();
        tick();
        start_c = '0;
        set_ins(0, 32'h0000_0A00);
        set_ins(2, 32'h0000_0C00);
        start_c = 4'b0101;
        tick();
        tick();
        start_c = '0;
        wait_idle();
        chk("t3_order", {served_q.size() == 3, served_q[0],
                         served_q[1], served_q[2]},
            {1'b1, 2'd1, 2'd2, 2'd0});

        // Busy client restarting with changing instructions.
        served_q.delete();
        next_lat = 3;
        for (int k = 0; k < 5; k++) begin
            set_ins(2, 32'h0440_0000 + 32'(k));
            start_c[2] = 1'b1;
            tick();
        end
        start_c = '0;
        wait_idle();
        chk("t4_count", served_q.size(), 1);
        chk("t4_result2", result_c[95:64], f(32'h0440_0000));

        // Reset while client 1 waits on the datapath.
        next_lat = 8;
        set_ins(1, 32'h0000_5151);
        start_c[1] = 1'b1;
        tick();
        tick();
        start_c = '0;
        for (int k = 0; k < 3; k++) tick();
        do_reset();
        tick();
        tick();
        resetn = 1'b1;
        served_q.delete();
        next_lat = 2;
        set_ins(3, 32'h0000_3333);
        start_c[3] = 1'b1;
        tick();
        tick();
        start_c = '0;
        wait_idle();
        chk("t5_order", {served_q.size() == 1, served_q[0]},
            {1'b1, 2'd3});
        chk("t5_result3", result_c[127:96], 32'h0000_6666);
        chk("t5_result1", result_c[63:32], 32'h0);

        // Ten back-to-back requests from client 0.
        next_lat = 0;
        m_done[0] = 0;
        for (int n = 0; n < 10; n++) begin
            ins = $urandom;
            set_ins(0, ins);
            start_c[0] = 1'b1;
            tick();
            tick();
            start_c = '0;
            wait_idle();
            chk("t6_result0", result_c[31:0], f(ins));
        end
        chk("t6_count", m_done[0], 10);

        // Random traffic from all clients.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) set_ins(i, $urandom);
            start_c = 4'($urandom) & 4'($urandom);
            tick();
        end
        start_c = '0;
        wait_idle();
        chk("t7_all_idle", finished_c, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule

// File: doc/dp_arbiter.md
# dp_arbiter

Four-client round-robin arbiter between the ant control FSMs (update/draw clients) and the single datapath instruction port. Each client keeps its existing 2-cycle-start / wait-for-finished handshake unchanged. The arbiter latches each request, serializes requests onto the datapath one at a time, and returns each client's result and completion on a dedicated per-client port.

## Interface
- `INSTR_W`, default 32: instruction width; equals `INSTRUCTION_WIDTH`.
- `RESULT_W`, default 32: result width; equals `RESULT_WIDTH`.
- `clock` input, 1: system clock; all state changes on its rising edge.
- `resetn` input, 1: reset; asynchronous, active-low.
- `start_c` input, 4: per-client start; bit i belongs to client i.
- `instruction_c` input, 4*INSTR_W: client i's instruction at bits [i*INSTR_W +: INSTR_W].
- `finished_c` output, 4: per-client finished; 1 = idle/done, 0 = request pending or in flight.
- `result_c` output, 4*RESULT_W: client i's last result at [i*RESULT_W +: RESULT_W].
- `start_dp` output, 1: start to datapath.
- `instruction_dp` output, INSTR_W: instruction to datapath.
- `finished_dp` input, 1: datapath finished.
- `result_dp` input, RESULT_W: datapath result; valid when `finished_dp` is 1.
- `owner` output, 2: index of the client currently granted; for debug.

## Operation
- Per-client registers: `busy[i]` and `instr_q[i]`. `finished_c = ~busy`.
- Capture: on a rising edge where `start_c[i]`=1 and `busy[i]`=0:
  - `busy[i]` <= 1.
  - `instr_q[i]` <= that client's slice of `instruction_c`.
- If `start_c[i]`=1 while `busy[i]`=1 (the second start cycle, or a protocol violation), the request is ignored and `instr_q[i]` is unchanged.
- Simultaneous starts from several clients are all captured in the same edge.
- States: IDLE, ISSUE, HOLD, WAIT.
  - IDLE: if any busy client is not yet served, grant the first one found starting from `rr_ptr` and moving upward mod 4. On the grant:
    - `owner` <= i.
    - `instruction_dp` <= `instr_q[i]`.
    - `start_dp` <= 1.
    - Go to ISSUE.
    - A client captured on this same edge is not eligible until the next edge.
  - ISSUE: `start_dp` stays 1; go to HOLD.
  - HOLD: `start_dp` <= 0; go to WAIT.
  - WAIT: on an edge with `finished_dp`=1:
    - `result_c[owner]` <= `result_dp`.
    - `busy[owner]` <= 0.
    - `rr_ptr` <= owner+1 (wraps 3 -> 0).
    - Go to IDLE.
- `instruction_dp` holds its value until the next grant.
- Unserved requests wait indefinitely. Round-robin bounds the wait to 3 transactions.
- Datapath requirement: `finished_dp` must be 0 by the first WAIT sample.
- Result slices for other clients are never disturbed.

## Timing
- Reset (async, immediate) values:
  - `start_dp`=0, `instruction_dp`=0, `owner`=0.
  - `finished_c`=4'b1111, `result_c`=0.
  - `busy`=0, `rr_ptr`=0, state IDLE.
- Reset mid-transaction abandons the transaction. `start_dp` drops at once; pending requests are lost.
- Uncontended timeline, client start first high after edge E0:
  - E1: capture; `finished_c[i]` low after E1, which satisfies the client's WAIT check at E2.
  - E2: grant; `start_dp` high from E2.
  - E4: `start_dp` low.
  - First WAIT sample at E5.
  - Datapath done sampled at Ek: `finished_c[i]` and `result_c[i]` update after Ek.
  - Next grant possible at Ek+1.
- `start_dp` is high for exactly 2 cycles per transaction.

## Test plan
- Single request:
  - Stimulus: client 0 issues 0x2000_0005; datapath model returns 0x0000_000A three cycles after start.
  - Required: `instruction_dp`=0x2000_0005; `start_dp` high exactly 2 cycles; `result_c[0]`=0xA; `finished_c[0]` returns to 1 one cycle after `finished_dp` is sampled high.
- Simultaneous requests:
  - Stimulus: clients 0, 1 and 3 start on the same edge.
  - Required: service order 0, 1, 3; `finished_c` low on bits 0, 1 and 3 from the edge after capture; each result lands only in its own slice.
- Round-robin fairness:
  - Stimulus: after client 1 is served, clients 0 and 2 are both pending.
  - Required: client 2 is served before client 0.
- Busy client restarts:
  - Stimulus: `start_c[2]` held high 5 cycles with the instruction changing each cycle.
  - Required: only the first-cycle instruction is captured and issued.
- Reset mid-transaction:
  - Stimulus: assert `resetn`=0 while in WAIT with client 1 owning.
  - Required: `start_dp`=0 and `finished_c`=4'b1111 immediately; after release, a new client 3 request completes normally.
- Back-to-back requests from one client:
  - Stimulus: client 0 issues 10 consecutive requests with random datapath latency of 1–8 cycles.
  - Required: 10 transactions, all results correct, never more than one transaction in flight.
